// File: rtl/hf_frame_seq.sv
// -----------------------------------------------------------------------------
// hf_frame_seq
//   Frame/line sequencer wrapped around the hole_filling post-processing core.
//   It accepts a raster disparity stream, gates hole_filling's enable/clken and
//   feeds it pixels. After the last input row it injects FLUSH_LINES zero lines
//   to drain the core's line-delay stages. The filled disparity that comes back
//   is re-framed with end-of-line and end-of-frame markers and handed downstream
//   through a one-entry output register with valid/ready backpressure.
//
// Ports
//   clk, rst          clock; asynchronous reset, active low
//   start             one-cycle pulse in IDLE: latch width/height, begin a frame
//   width, height     frame geometry (1..2047), sampled at start
//   in_valid/in_ready/in_data   input pixel stream {dismatch, occl, disp}
//   hf_clken, hf_enable, hf_din, hf_width   drive the hole_filling core
//   hf_valid, hf_disp            results returned by the hole_filling core
//   out_valid/out_ready/out_disp/out_eol/out_eof   framed output stream
//   busy              high from start accept until the frame completes
//   frame_done        one-cycle pulse when a frame completes (or times out)
//   err_timeout       sticky watchdog flag, cleared by the next start
// -----------------------------------------------------------------------------
module hf_frame_seq #(
    parameter int DWIDTH      = 7,
    parameter int FLUSH_LINES = 3,
    parameter int TO_CYC      = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [10:0]       width,
    input  logic [10:0]       height,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH+1:0] in_data,
    output logic              hf_clken,
    output logic              hf_enable,
    output logic [DWIDTH+1:0] hf_din,
    output logic [10:0]       hf_width,
    input  logic              hf_valid,
    input  logic [DWIDTH-1:0] hf_disp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_disp,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic              frame_done,
    output logic              err_timeout
);

    localparam int WD_W = $clog2(TO_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TO_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LINE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [10:0]       width_q, width_d;
    logic [10:0]       height_q, height_d;
    logic [10:0]       col_q, col_d;
    logic [10:0]       row_q, row_d;
    logic [10:0]       ocol_q, ocol_d;
    logic [10:0]       orow_q, orow_d;
    logic [12:0]       inj_q, inj_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              out_all_q, out_all_d;
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] out_disp_q, out_disp_d;
    logic              out_eol_q, out_eol_d;
    logic              out_eof_q, out_eof_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;

    logic        clken;
    logic        in_frame;
    logic        accept;
    logic        inject;
    logic        eof_xfer;
    logic        load;
    logic        ld_eol;
    logic [12:0] flush_total;

    // The whole datapath, including hole_filling, advances only while the
    // output register is empty or being drained this cycle.
    assign clken       = ~out_valid_q | out_ready;
    assign in_frame    = (state_q == S_LINE) || (state_q == S_FLUSH);
    assign accept      = (state_q == S_LINE) && in_valid && clken;
    assign eof_xfer    = out_valid_q && out_ready && out_eof_q;
    assign flush_total = 13'(FLUSH_LINES) * {2'b00, width_q};
    // Padding stops as soon as the frame's last pixel leaves, even if some of
    // the flush lines were never needed.
    assign inject      = (state_q == S_FLUSH) && clken && (inj_q < flush_total) && !eof_xfer;
    // Results beyond width*height belong to padding and are dropped.
    assign load        = clken && hf_valid && in_frame && !out_all_q;
    assign ld_eol      = (ocol_q == width_q - 11'd1);

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        col_d        = col_q;
        row_d        = row_q;
        ocol_d       = ocol_q;
        orow_d       = orow_q;
        inj_d        = inj_q;
        wd_d         = wd_q;
        out_all_d    = out_all_q;
        out_valid_d  = out_valid_q;
        out_disp_d   = out_disp_q;
        out_eol_d    = out_eol_q;
        out_eof_d    = out_eof_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        err_d        = err_q;

        // Input-side sequencing
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LINE;
                    width_d   = width;
                    height_d  = height;
                    col_d     = '0;
                    row_d     = '0;
                    ocol_d    = '0;
                    orow_d    = '0;
                    inj_d     = '0;
                    wd_d      = '0;
                    out_all_d = 1'b0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_LINE: begin
                if (accept) begin
                    if (col_q == width_q - 11'd1) begin
                        col_d = '0;
                        if (row_q == height_q - 11'd1) begin
                            row_d   = '0;
                            state_d = S_FLUSH;
                        end else begin
                            row_d = row_q + 11'd1;
                        end
                    end else begin
                        col_d = col_q + 11'd1;
                    end
                end
            end
            S_FLUSH: begin
                if (inject) begin
                    inj_d = inj_q + 13'd1;
                end
                // Watchdog: stalled cycles do not count, only clocked ones
                // that return nothing from the core.
                if (clken) begin
                    if (hf_valid) begin
                        wd_d = '0;
                    end else if (wd_q != WD_MAX) begin
                        wd_d = wd_q + 1'b1;
                        if (wd_q + 1'b1 == WD_MAX) begin
                            err_d        = 1'b1;
                            frame_done_d = 1'b1;
                            busy_d       = 1'b0;
                            state_d      = S_IDLE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output register: refilled or emptied only on clocked cycles,
        // otherwise it holds its pixel until downstream takes it.
        if (clken) begin
            out_valid_d = load;
            out_eol_d   = 1'b0;
            out_eof_d   = 1'b0;
            if (load) begin
                out_disp_d = hf_disp;
                out_eol_d  = ld_eol;
                out_eof_d  = ld_eol && (orow_q == height_q - 11'd1);
                if (ld_eol) begin
                    ocol_d = '0;
                    if (orow_q == height_q - 11'd1) begin
                        orow_d    = '0;
                        out_all_d = 1'b1;
                    end else begin
                        orow_d = orow_q + 11'd1;
                    end
                end else begin
                    ocol_d = ocol_q + 11'd1;
                end
            end
        end

        // Last pixel handed downstream: completion beats everything else.
        if (eof_xfer && in_frame) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            err_d        = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            ocol_q       <= '0;
            orow_q       <= '0;
            inj_q        <= '0;
            wd_q         <= '0;
            out_all_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_disp_q   <= '0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ocol_q       <= ocol_d;
            orow_q       <= orow_d;
            inj_q        <= inj_d;
            wd_q         <= wd_d;
            out_all_q    <= out_all_d;
            out_valid_q  <= out_valid_d;
            out_disp_q   <= out_disp_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign hf_clken    = clken;
    assign in_ready    = (state_q == S_LINE) && clken;
    assign hf_enable   = accept | inject;
    // Padding pixels are valid, zero-disparity, non-hole pixels.
    assign hf_din      = accept ? in_data : '0;
    assign hf_width    = width_q;
    assign out_valid   = out_valid_q;
    assign out_disp    = out_disp_q;
    assign out_eol     = out_eol_q;
    assign out_eof     = out_eof_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign err_timeout = err_q;

endmodule
